bht_btb_sat: RTL and testbench
==============================

Name: bht_btb_sat

Overview:
- Parametrised direct-mapped branch history / target buffer with N-bit saturating prediction counters, tag check and valid bits.
- Fetch stage issues a lookup and receives a registered prediction (taken + target) one cycle later.
- Decode/execute posts resolved branch outcomes on the update port.
- Adds flush, hysteresis counters and saturating performance counters.

Parameters:
- ADDR_W, 32, PC/target width.
- IDX_W, 3, index bits; ENTRIES = 2**IDX_W.
- CTR_W, 2, prediction counter width (≥1).
- STAT_W, 16, performance counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- lk_valid  input  1  lookup request.
- lk_pc  input  ADDR_W  PC being fetched.
- lk_rsp_valid  output  1  registered response valid (lk_valid delayed 1 cycle).
- lk_hit  output  1  tag match and entry valid.
- lk_taken  output  1  hit and counter MSB = 1.
- lk_target  output  ADDR_W  stored target (0 when no hit).
- upd_valid  input  1  resolved-branch update.
- upd_pc  input  ADDR_W  branch PC.
- upd_taken  input  1  actual outcome.
- upd_target  input  ADDR_W  actual target.
- upd_pred  input  1  prediction that was used for this branch.
- flush  input  1  invalidate all entries.
- clr_stats  input  1  zero performance counters.
- stat_lookups  output  STAT_W  lookups issued.
- stat_hits  output  STAT_W  lookups that hit.
- stat_mispred  output  STAT_W  updates with upd_pred != upd_taken.

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2].
- Per entry: valid, tag, target, ctr[CTR_W-1:0].
- Reset (async, rst_n=0):
  - All valid = 0, ctr = WEAK_NT (2**(CTR_W-1) - 1), tags and targets = 0.
  - All outputs and stats = 0.
  - Reset mid-lookup drops the pending response: lk_rsp_valid = 0 on the first edge after release unless lk_valid is high on that edge.
- Lookup: sampled on posedge when lk_valid = 1. Response registered on that same edge and appears in the following cycle.
  - lk_hit = valid & tag match.
  - lk_taken = lk_hit & ctr[MSB].
  - lk_target = lk_hit ? target : 0.
  - When lk_valid = 0: lk_rsp_valid = 0, other outputs hold their last values.
- Lookup and update on the same index in the same cycle: lookup reads pre-update state (no bypass).
- Update on posedge when upd_valid = 1, hit (valid & tag match):
  - Saturating increment of ctr if upd_taken, saturating decrement if not taken.
  - Saturation limits are 2**CTR_W - 1 and 0.
  - target <= upd_target if upd_taken.
- Update on posedge when upd_valid = 1, miss (invalid, or tag differs):
  - Allocate/replace: valid = 1, tag = new tag, target = upd_target.
  - ctr = upd_taken ? WEAK_T (2**(CTR_W-1)) : WEAK_NT.
  - The previous occupant's history is discarded.
- Flush (posedge, flush = 1): all valid = 0, all ctr = WEAK_NT.
  - Has priority over a same-cycle update; that update is dropped.
  - A same-cycle lookup still returns pre-flush state.
- Stats: each increments by 1 per qualifying event and saturates at all-ones (no wrap).
  - stat_hits counts when the response is produced, i.e. on the lookup edge.
  - clr_stats zeroes all three and has priority over same-cycle increments.
  - Stats are unaffected by flush.
- CTR_W = 1: counter degenerates to last-outcome bit; WEAK_NT = 0, WEAK_T = 1.

Test Plan:
- Reset then lookup pc 0x40 -> next cycle lk_rsp_valid = 1, lk_hit = 0, lk_taken = 0, lk_target = 0; stat_lookups = 1, stat_hits = 0.
- Update pc 0x40 taken target 0x100, then lookup 0x40 -> lk_hit = 1, lk_taken = 1 (ctr = 2), lk_target = 0x100. Three more taken updates -> ctr saturates at 3. Two not-taken -> ctr = 1, lk_taken = 0.
- Alias: update 0x40 taken, then update 0x60 (same index, IDX_W = 3) not-taken target 0x200 -> lookup 0x40 misses; lookup 0x60 hits with lk_taken = 0, lk_target = 0x200.
- Same-cycle lookup and update to 0x40 (entry ctr = 1, update taken) -> response shows lk_taken = 0; lookup the following cycle shows lk_taken = 1.
- Flush asserted together with an update on a populated table -> all subsequent lookups miss, update not applied. Assert rst_n low with lk_valid high -> all outputs 0 asynchronously.
- STAT_W = 4: 20 updates with upd_pred != upd_taken -> stat_mispred = 15 (holds). clr_stats plus a same-cycle mispredicted update -> 0.

Source files
------------

// File: rtl/bht_btb_sat.sv
// rtl/bht_btb_sat.sv - direct-mapped branch history/target buffer with saturating counters
module bht_btb_sat #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 3,
    parameter int CTR_W  = 2,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lk_valid,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              lk_rsp_valid,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [ADDR_W-1:0] lk_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred,
    input  logic              flush,
    input  logic              clr_stats,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_mispred
);
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'((2 ** (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(2 ** (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_MIN = '0;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             lk_hit_c, upd_hit_c;
    logic             unused_pc_bits;

    // The low two PC bits are the instruction byte offset and never select an entry.
    assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

    assign lk_idx    = lk_pc[IDX_W+1:2];
    assign lk_tag    = lk_pc[ADDR_W-1:IDX_W+2];
    assign upd_idx   = upd_pc[IDX_W+1:2];
    assign upd_tag   = upd_pc[ADDR_W-1:IDX_W+2];
    assign lk_hit_c  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign upd_hit_c = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Registered lookup response from pre-update table state; holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_rsp_valid <= 1'b0;
            lk_hit       <= 1'b0;
            lk_taken     <= 1'b0;
            lk_target    <= '0;
        end else begin
            lk_rsp_valid <= lk_valid;
            if (lk_valid) begin
                lk_hit    <= lk_hit_c;
                lk_taken  <= lk_hit_c && ctr_q[lk_idx][CTR_W-1];
                lk_target <= lk_hit_c ? tgt_q[lk_idx] : '0;
            end
        end
    end

    // Table maintenance: flush wins over update; hits train, misses allocate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= WEAK_NT;
            end
        end else if (flush) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= WEAK_NT;
            end
        end else if (upd_valid) begin
            if (upd_hit_c) begin
                if (upd_taken) begin
                    tgt_q[upd_idx] <= upd_target;
                    if (ctr_q[upd_idx] != CTR_MAX)
                        ctr_q[upd_idx] <= ctr_q[upd_idx] + CTR_W'(1);
                end else if (ctr_q[upd_idx] != CTR_MIN) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - CTR_W'(1);
                end
            end else begin
                valid_q[upd_idx] <= 1'b1;
                tag_q[upd_idx]   <= upd_tag;
                tgt_q[upd_idx]   <= upd_target;
                ctr_q[upd_idx]   <= upd_taken ? WEAK_T : WEAK_NT;
            end
        end
    end

    // Saturating performance counters; clear beats same-cycle increments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_mispred <= '0;
        end else if (clr_stats) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_mispred <= '0;
        end else begin
            if (lk_valid && stat_lookups != STAT_MAX)
                stat_lookups <= stat_lookups + STAT_W'(1);
            if (lk_valid && lk_hit_c && stat_hits != STAT_MAX)
                stat_hits <= stat_hits + STAT_W'(1);
            if (upd_valid && (upd_pred != upd_taken) && stat_mispred != STAT_MAX)
                stat_mispred <= stat_mispred + STAT_W'(1);
        end
    end
endmodule

// File: tb/tb_bht_btb_sat.sv
// tb/tb_bht_btb_sat.sv - randomized and directed checks of bht_btb_sat against a behavioural model
module tb_bht_btb_sat;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        lk_valid, upd_valid, upd_taken, upd_pred, flush, clr_stats;
    logic [31:0] lk_pc, upd_pc, upd_target;
    logic        lk_rsp_valid, lk_hit, lk_taken;
    logic [31:0] lk_target;
    logic [3:0]  stat_lookups, stat_hits, stat_mispred;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model: 8 entries, 2-bit counters (0..3), 4-bit stats (0..15)
    bit          m_valid [8];
    int          m_tag   [8];
    logic [31:0] m_tgt   [8];
    int          m_ctr   [8];
    logic        e_rsp, e_hit, e_taken;
    logic [31:0] e_target;
    int          e_look, e_hits, e_mis;

    bht_btb_sat #(.ADDR_W(32), .IDX_W(3), .CTR_W(2), .STAT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .lk_valid(lk_valid), .lk_pc(lk_pc),
        .lk_rsp_valid(lk_rsp_valid), .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_target(lk_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred(upd_pred),
        .flush(flush), .clr_stats(clr_stats),
        .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        e_rsp = 0; e_hit = 0; e_taken = 0; e_target = 0;
        e_look = 0; e_hits = 0; e_mis = 0;
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model, sample 1 time unit after the rising edge.
    task automatic step(input logic lkv, input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utgt, input logic up, input logic fl, input logic clr);
        int li, ui;
        bit lhit, uhit;
        @(negedge clk);
        lk_valid = lkv; lk_pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
        upd_target = utgt; upd_pred = up; flush = fl; clr_stats = clr;
        li = (lpc >> 2) % 8;
        ui = (upc >> 2) % 8;
        lhit = m_valid[li] && (m_tag[li] == int'(lpc >> 5));
        uhit = m_valid[ui] && (m_tag[ui] == int'(upc >> 5));
        e_rsp = lkv;
        if (lkv) begin
            e_hit = lhit;
            e_taken = lhit && (m_ctr[li] >= 2);
            e_target = lhit ? m_tgt[li] : 32'h0;
        end
        if (clr) begin
            e_look = 0; e_hits = 0; e_mis = 0;
        end else begin
            if (lkv) e_look = (e_look + 1 > 15) ? 15 : e_look + 1;
            if (lkv && lhit) e_hits = (e_hits + 1 > 15) ? 15 : e_hits + 1;
            if (uv && (up != ut)) e_mis = (e_mis + 1 > 15) ? 15 : e_mis + 1;
        end
        if (fl) begin
            for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_ctr[i] = 1; end
        end else if (uv) begin
            if (uhit) begin
                if (ut) begin m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1; m_tgt[ui] = utgt; end
                else m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
            end else begin
                m_valid[ui] = 1; m_tag[ui] = int'(upc >> 5); m_tgt[ui] = utgt; m_ctr[ui] = ut ? 2 : 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lookup(input logic [31:0] pc);
        step(1, pc, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic update(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        step(0, 0, 1, pc, t, tgt, t, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; lk_valid = 1; lk_pc = 32'h40; upd_valid = 0; upd_pc = 0; upd_taken = 0;
        upd_target = 0; upd_pred = 0; flush = 0; clr_stats = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({lk_rsp_valid, lk_hit, lk_taken} !== 3'b000 || lk_target !== 0) begin n_fail++; $display("FAIL reset_outputs: got %b/%h expected 000/0", {lk_rsp_valid, lk_hit, lk_taken}, lk_target); end
        n_checks++; if ({stat_lookups, stat_hits, stat_mispred} !== 12'h0) begin n_fail++; $display("FAIL reset_stats: got %h expected 000", {stat_lookups, stat_hits, stat_mispred}); end
        @(negedge clk); lk_valid = 0; rst_n = 1'b1;
        idle();
        n_checks++; if (lk_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_rsp: got %b expected 0", lk_rsp_valid); end
    endtask

    task automatic test_basic();
        lookup(32'h40);
        n_checks++; if ({lk_rsp_valid, lk_hit, lk_taken} !== 3'b100 || lk_target !== 0) begin n_fail++; $display("FAIL first_lookup: got %b/%h expected 100/0", {lk_rsp_valid, lk_hit, lk_taken}, lk_target); end
        n_checks++; if (stat_lookups !== 4'd1 || stat_hits !== 4'd0) begin n_fail++; $display("FAIL first_stats: got %0d/%0d expected 1/0", stat_lookups, stat_hits); end
        update(32'h40, 1, 32'h100);
        lookup(32'h40);
        n_checks++; if ({lk_hit, lk_taken} !== 2'b11 || lk_target !== 32'h100) begin n_fail++; $display("FAIL alloc_taken: got %b/%h expected 11/100", {lk_hit, lk_taken}, lk_target); end
        repeat (3) update(32'h40, 1, 32'h100);
        update(32'h40, 0, 32'h0);
        lookup(32'h40);
        n_checks++; if (lk_taken !== 1'b1) begin n_fail++; $display("FAIL saturate_high: got %b expected 1", lk_taken); end
        update(32'h40, 0, 32'h0);
        lookup(32'h40);
        n_checks++; if ({lk_hit, lk_taken} !== 2'b10 || lk_target !== 32'h100) begin n_fail++; $display("FAIL decrement: got %b/%h expected 10/100", {lk_hit, lk_taken}, lk_target); end
        idle();
        n_checks++; if (lk_rsp_valid !== 1'b0 || lk_hit !== 1'b1 || lk_target !== 32'h100) begin n_fail++; $display("FAIL idle_hold: got %b%b/%h expected 01/100", lk_rsp_valid, lk_hit, lk_target); end
    endtask

    task automatic test_same_cycle();
        step(1, 32'h40, 1, 32'h40, 1, 32'h140, 1, 0, 0);
        n_checks++; if ({lk_hit, lk_taken} !== 2'b10 || lk_target !== 32'h100) begin n_fail++; $display("FAIL same_cycle_pre: got %b/%h expected 10/100", {lk_hit, lk_taken}, lk_target); end
        lookup(32'h40);
        n_checks++; if (lk_taken !== 1'b1 || lk_target !== 32'h140) begin n_fail++; $display("FAIL same_cycle_post: got %b/%h expected 1/140", lk_taken, lk_target); end
    endtask

    task automatic test_alias();
        update(32'h40, 1, 32'h100);
        update(32'h60, 0, 32'h200);
        lookup(32'h40);
        n_checks++; if ({lk_hit, lk_taken} !== 2'b00 || lk_target !== 0) begin n_fail++; $display("FAIL alias_evicted: got %b/%h expected 00/0", {lk_hit, lk_taken}, lk_target); end
        lookup(32'h60);
        n_checks++; if ({lk_hit, lk_taken} !== 2'b10 || lk_target !== 32'h200) begin n_fail++; $display("FAIL alias_new: got %b/%h expected 10/200", {lk_hit, lk_taken}, lk_target); end
    endtask

    task automatic test_flush();
        update(32'h44, 1, 32'h300);
        update(32'h48, 1, 32'h304);
        step(1, 32'h44, 1, 32'h4c, 1, 32'h308, 1, 1, 0);
        n_checks++; if (lk_hit !== 1'b1 || lk_target !== 32'h300) begin n_fail++; $display("FAIL flush_same_cycle_lookup: got %b/%h expected 1/300", lk_hit, lk_target); end
        for (int i = 0; i < 6; i++) begin
            lookup(32'h40 + 32'(4 * i));
            n_checks++; if (lk_hit !== 1'b0 || lk_target !== 0) begin n_fail++; $display("FAIL flush_miss_%0d: got %b/%h expected 0/0", i, lk_hit, lk_target); end
        end
        lookup(32'h60);
        n_checks++; if (lk_hit !== 1'b0) begin n_fail++; $display("FAIL flush_miss_60: got %b expected 0", lk_hit); end
    endtask

    task automatic test_stats_sat();
        for (int i = 0; i < 20; i++) step(0, 0, 1, 32'($urandom), 1, 32'($urandom), 0, 0, 0);
        n_checks++; if (stat_mispred !== 4'd15) begin n_fail++; $display("FAIL mispred_saturate: got %0d expected 15", stat_mispred); end
        n_checks++; if (stat_mispred !== 4'(e_mis) || stat_lookups !== 4'(e_look) || stat_hits !== 4'(e_hits)) begin n_fail++; $display("FAIL stats_model: got %0d/%0d/%0d expected %0d/%0d/%0d", stat_lookups, stat_hits, stat_mispred, e_look, e_hits, e_mis); end
        step(1, 32'h40, 1, 32'h40, 1, 32'h0, 0, 0, 1);
        n_checks++; if ({stat_lookups, stat_hits, stat_mispred} !== 12'h0) begin n_fail++; $display("FAIL clr_priority: got %h expected 000", {stat_lookups, stat_hits, stat_mispred}); end
    endtask

    task automatic test_random();
        logic [31:0] lpc, upc;
        for (int n = 0; n < 400; n++) begin
            lpc = 32'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
            upc = 32'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
            step(1'($urandom_range(0, 3) != 0), lpc, 1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)),
                 32'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 29) == 0));
            n_checks++; if ({lk_rsp_valid, lk_hit, lk_taken} !== {e_rsp, e_hit, e_taken} || lk_target !== e_target) begin n_fail++; $display("FAIL rand_rsp_%0d: got %b/%h expected %b/%h", n, {lk_rsp_valid, lk_hit, lk_taken}, lk_target, {e_rsp, e_hit, e_taken}, e_target); end
            n_checks++; if (stat_lookups !== 4'(e_look) || stat_hits !== 4'(e_hits) || stat_mispred !== 4'(e_mis)) begin n_fail++; $display("FAIL rand_stats_%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", n, stat_lookups, stat_hits, stat_mispred, e_look, e_hits, e_mis); end
        end
    endtask

    task automatic test_async_reset();
        update(32'h60, 1, 32'h500);
        lookup(32'h60);
        @(negedge clk);
        lk_valid = 1; lk_pc = 32'h60;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({lk_rsp_valid, lk_hit, lk_taken} !== 3'b000 || lk_target !== 0 || {stat_lookups, stat_hits, stat_mispred} !== 12'h0) begin n_fail++; $display("FAIL async_reset: got %b/%h/%h expected 000/0/000", {lk_rsp_valid, lk_hit, lk_taken}, lk_target, {stat_lookups, stat_hits, stat_mispred}); end
        model_reset();
        @(negedge clk); lk_valid = 0; rst_n = 1'b1;
        idle();
        n_checks++; if (lk_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_drop: got %b expected 0", lk_rsp_valid); end
        lookup(32'h60);
        n_checks++; if ({lk_rsp_valid, lk_hit} !== 2'b10 || stat_lookups !== 4'd1) begin n_fail++; $display("FAIL async_reset_table: got %b/%0d expected 10/1", {lk_rsp_valid, lk_hit}, stat_lookups); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_cycle();
        test_alias();
        test_flush();
        test_stats_sat();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
